// File: rtl/inst_fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues one word fetch at a time,
// and holds each fetched instruction for decode until it is accepted or redirected.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state, state_next;
    logic        kill, kill_next;
    logic [31:0] pc, pc_next;
    logic        load_if, drop_if;

    assign imem_req_valid = (state == S_REQ) && !rst;
    assign imem_req_addr  = pc;

    // kill marks an in-flight response whose fetch was superseded by a redirect
    always_comb begin
        state_next = state;
        kill_next  = kill;
        pc_next    = pc;
        load_if    = 1'b0;
        drop_if    = 1'b0;
        if (redirect_valid) begin
            pc_next = redirect_pc & ~32'h0000_0003;
            drop_if = 1'b1;
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_next = S_WAIT;
                        kill_next  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_next = S_REQ;
                        kill_next  = 1'b0;
                    end else begin
                        kill_next = 1'b1;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill) begin
                            kill_next  = 1'b0;
                            state_next = S_REQ;
                        end else begin
                            load_if    = 1'b1;
                            pc_next    = pc + 32'd4;
                            state_next = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (if_ready) begin
                        drop_if    = 1'b1;
                        state_next = S_REQ;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            kill     <= 1'b0;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_inst  <= NOP;
            if_pc    <= 32'h0000_0000;
        end else begin
            state <= state_next;
            kill  <= kill_next;
            pc    <= pc_next;
            if (load_if) begin
                if_valid <= 1'b1;
                if_inst  <= imem_rsp_data;
                if_pc    <= pc;
            end else if (drop_if) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule
